mem_ctrl: RTL

//  Sole master of the byte-wide unified RAM port. Arbitrates IF instruction fetches against MEM-stage

---
 rtl/mem_ctrl_pkg.sv | 24 ++
 rtl/mem_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the unified-RAM memory controller: access sizes,
// FSM state encodings and the size-to-byte-count helper.
package mem_ctrl_pkg;

  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_IF_RD  = 3'd1;
  localparam logic [2:0] ST_MEM_RD = 3'd2;
  localparam logic [2:0] ST_MEM_WR = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // Size code 3 is treated as a word access.
  function automatic logic [2:0] size_to_len(input logic [1:0] size);
    case (size)
      MEM_BYTE: return 3'd1;
      MEM_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial master of the unified RAM port: arbitrates IF fetches against
// MEM loads/stores and keeps the last fetched word for zero-latency re-serve.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int RAM_ADDR_W = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [31:0]           if_addr,
  output logic                  if_done,
  output logic [31:0]           if_inst,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [1:0]            mem_size,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  output logic                  mem_done,
  output logic [31:0]           mem_rdata,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic                  ram_we,
  output logic [7:0]            ram_dout,
  input  logic [7:0]            ram_din,
  output logic                  stall_from_if,
  output logic                  stall_from_mem
);

  logic [2:0]            state_reg, state_next;
  logic [2:0]            cnt_reg, cnt_next;
  logic [2:0]            len_reg, len_next;
  logic [31:0]           addr_reg, addr_next;
  logic [31:0]           wdata_reg, wdata_next;
  logic [31:0]           data_reg, data_next;
  logic [31:0]           data_asm;
  logic [31:0]           hold_addr_reg;
  logic                  hold_valid_reg;
  logic [31:0]           if_inst_reg;
  logic [31:0]           mem_rdata_reg;
  logic                  mem_done_reg;
  logic [RAM_ADDR_W-1:0] ram_addr_reg, ram_addr_next;
  logic                  ram_we_reg, ram_we_next;
  logic [7:0]            ram_dout_reg, ram_dout_next;
  logic                  active_next;
  logic                  finishing;

  // Byte c-1 arrives on ram_din while the counter reads c.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign data_asm[8*gi +: 8] = (cnt_reg == 3'(gi + 1)) ? ram_din : data_reg[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    len_next   = len_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    data_next  = data_reg;
    case (state_reg)
      ST_IDLE: begin
        if (mem_req) begin
          state_next = mem_we ? ST_MEM_WR : ST_MEM_RD;
          cnt_next   = 3'd0;
          len_next   = size_to_len(mem_size);
          addr_next  = mem_addr;
          wdata_next = mem_wdata;
          data_next  = 32'd0;
        end else if (if_req && !if_done) begin
          state_next = ST_IF_RD;
          cnt_next   = 3'd0;
          len_next   = 3'd4;
          addr_next  = if_addr;
          data_next  = 32'd0;
        end
      end
      ST_IF_RD, ST_MEM_RD: begin
        if (cnt_reg != 3'd0) data_next = data_asm;
        if (cnt_reg == len_reg) state_next = ST_DONE;
        else cnt_next = cnt_reg + 3'd1;
      end
      ST_MEM_WR: begin
        if (cnt_reg == len_reg) state_next = ST_DONE;
        else cnt_next = cnt_reg + 3'd1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // RAM outputs are registered from next-state values so byte c is on the port while cnt_reg == c.
  always_comb begin
    active_next   = (state_next == ST_IF_RD || state_next == ST_MEM_RD || state_next == ST_MEM_WR)
                    && (cnt_next < len_next);
    ram_addr_next = active_next ? addr_next[RAM_ADDR_W-1:0] + RAM_ADDR_W'(cnt_next) : '0;
    ram_we_next   = active_next && (state_next == ST_MEM_WR);
    ram_dout_next = 8'd0;
    if (ram_we_next) begin
      case (cnt_next[1:0])
        2'd0:    ram_dout_next = wdata_next[7:0];
        2'd1:    ram_dout_next = wdata_next[15:8];
        2'd2:    ram_dout_next = wdata_next[23:16];
        default: ram_dout_next = wdata_next[31:24];
      endcase
    end
  end

  assign finishing = (state_next == ST_DONE) && (state_reg != ST_DONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= 3'd0;
      len_reg        <= 3'd0;
      addr_reg       <= 32'd0;
      wdata_reg      <= 32'd0;
      data_reg       <= 32'd0;
      hold_addr_reg  <= 32'd0;
      hold_valid_reg <= 1'b0;
      if_inst_reg    <= 32'd0;
      mem_rdata_reg  <= 32'd0;
      mem_done_reg   <= 1'b0;
      ram_addr_reg   <= '0;
      ram_we_reg     <= 1'b0;
      ram_dout_reg   <= 8'd0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      len_reg      <= len_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      data_reg     <= data_next;
      ram_addr_reg <= ram_addr_next;
      ram_we_reg   <= ram_we_next;
      ram_dout_reg <= ram_dout_next;
      mem_done_reg <= finishing && (state_reg == ST_MEM_RD || state_reg == ST_MEM_WR);
      if (finishing && state_reg == ST_MEM_RD) mem_rdata_reg <= data_asm;
      if (finishing && state_reg == ST_IF_RD) begin
        if_inst_reg    <= data_asm;
        hold_addr_reg  <= addr_reg;
        hold_valid_reg <= 1'b1;
      end
      // A store may overwrite the held instruction, so drop it.
      if (finishing && state_reg == ST_MEM_WR) hold_valid_reg <= 1'b0;
    end
  end

  assign if_done        = if_req && hold_valid_reg && (if_addr == hold_addr_reg);
  assign if_inst        = if_inst_reg;
  assign mem_done       = mem_done_reg;
  assign mem_rdata      = mem_rdata_reg;
  assign ram_addr       = ram_addr_reg;
  assign ram_we         = ram_we_reg;
  assign ram_dout       = ram_dout_reg;
  assign stall_from_if  = if_req && !if_done;
  assign stall_from_mem = mem_req && !mem_done;

endmodule
